// File: rtl/tdm_demux_pkg.sv
// Shared constants and state encoding for the 8-lane TDM demultiplexer.
package tdm_demux_pkg;

  localparam int NLANES = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

endpackage

// File: rtl/demux1_8.sv
// 3-bit lane index plus enable decoded into a one-hot lane write strobe.
module demux1_8
  import tdm_demux_pkg::*;
(
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_en,
  output logic [NLANES-1:0] o_strobe
);

  // One-hot decode, all zero when not enabled
  always_comb begin
    o_strobe = '0;
    if (i_en) o_strobe[i_sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux8.sv
// 8-lane TDM demultiplexer: words are steered to y0..y7 either round-robin
// or by a manual select; a frame is complete once every lane was written.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   FILL  | collecting lanes; d_ready=1, frame_ack ignored
//   FULL  | all 8 lanes written; d_ready=0, waiting for frame_ack
module tdm_demux8
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             auto_mode,
  input  logic             s2,
  input  logic             s1,
  input  logic             s0,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] y4,
  output logic [WIDTH-1:0] y5,
  output logic [WIDTH-1:0] y6,
  output logic [WIDTH-1:0] y7,
  output logic             frame_valid,
  input  logic             frame_ack
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NLANES-1:0]   r_mask;
  logic [SEL_W-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_y [NLANES];

  logic                w_xfer;
  logic                w_ack_take;
  logic [SEL_W-1:0]    w_lane;
  logic [NLANES-1:0]   w_strobe;
  logic [NLANES-1:0]   w_mask_nxt;

  assign w_xfer     = d_valid && d_ready;
  assign w_ack_take = (r_state == FULL) && frame_ack;
  assign w_lane     = auto_mode ? r_cnt : {s2, s1, s0};
  assign w_mask_nxt = r_mask | w_strobe;

  demux1_8 u_demux (
    .i_sel    (w_lane),
    .i_en     (w_xfer),
    .o_strobe (w_strobe)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; FULL is entered on the same edge the
  // last missing lane is written, so frame_valid lines up with its data
  always_comb begin
    w_state_nxt = r_state;
    frame_valid = 1'b0;
    d_ready     = 1'b1;
    case (r_state)
      FILL: begin
        if (w_mask_nxt == {NLANES{1'b1}}) w_state_nxt = FULL;
      end
      FULL: begin
        frame_valid = 1'b1;
        d_ready     = 1'b0;
        if (frame_ack) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // Lane mask and round-robin counter; ack restarts the frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mask <= '0;
      r_cnt  <= '0;
    end else if (w_ack_take) begin
      r_mask <= '0;
      r_cnt  <= '0;
    end else begin
      r_mask <= w_mask_nxt;
      if (w_xfer && auto_mode) r_cnt <= r_cnt + 3'd1;
    end
  end

  // Lane data registers; only reset clears them, never ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NLANES; i++) r_y[i] <= '0;
    end else begin
      for (int i = 0; i < NLANES; i++)
        if (w_strobe[i]) r_y[i] <= d;
    end
  end

  assign y0 = r_y[0];
  assign y1 = r_y[1];
  assign y2 = r_y[2];
  assign y3 = r_y[3];
  assign y4 = r_y[4];
  assign y5 = r_y[5];
  assign y6 = r_y[6];
  assign y7 = r_y[7];

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: auto fill, backpressure, reset mid-frame,
// manual overwrite and mixed-mode frames with hand-computed expectations.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d;
  logic       d_valid;
  logic       d_ready;
  logic       auto_mode;
  logic       s2, s1, s0;
  logic [3:0] y0, y1, y2, y3, y4, y5, y6, y7;
  logic       frame_valid;
  logic       frame_ack;

  int n_checks = 0;
  int n_fail   = 0;

  tdm_demux8 #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .d           (d),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .auto_mode   (auto_mode),
    .s2          (s2),
    .s1          (s1),
    .s0          (s0),
    .y0          (y0),
    .y1          (y1),
    .y2          (y2),
    .y3          (y3),
    .y4          (y4),
    .y5          (y5),
    .y6          (y6),
    .y7          (y7),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] get_y(input int i);
    case (i)
      0: return y0;
      1: return y1;
      2: return y2;
      3: return y3;
      4: return y4;
      5: return y5;
      6: return y6;
      default: return y7;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_y(input string tag, input logic [3:0] e0, e1, e2, e3,
                           input logic [3:0] e4, e5, e6, e7);
    logic [3:0] exp [8];
    exp = '{e0, e1, e2, e3, e4, e5, e6, e7};
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_y%0d", tag, i), {4'h0, get_y(i)}, {4'h0, exp[i]});
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input int lane);
    {s2, s1, s0} = lane[2:0];
  endtask

  initial begin
    rst_n = 1'b0; d = '0; d_valid = 1'b0; auto_mode = 1'b1;
    s2 = 1'b0; s1 = 1'b0; s0 = 1'b0; frame_ack = 1'b0;
    tick();
    tick();
    chk_all_y("reset", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("reset_fv", {7'd0, frame_valid}, 8'd0);
    chk("reset_rdy", {7'd0, d_ready}, 8'd1);

    // Auto fill 1..8
    rst_n = 1'b1; auto_mode = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      d = 4'(i + 1);
      tick();
      chk($sformatf("auto_fv_%0d", i), {7'd0, frame_valid}, (i == 7) ? 8'd1 : 8'd0);
    end
    chk_all_y("auto", 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8);
    chk("auto_rdy", {7'd0, d_ready}, 8'd0);

    // Backpressure: word held while frame pending
    d = 4'd9;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp_y0_%0d", i), {4'h0, y0}, 8'd1);
      chk($sformatf("bp_fv_%0d", i), {7'd0, frame_valid}, 8'd1);
    end
    frame_ack = 1'b1;
    tick();
    chk("ack_fv", {7'd0, frame_valid}, 8'd0);
    chk("ack_rdy", {7'd0, d_ready}, 8'd1);
    chk("ack_y0_kept", {4'h0, y0}, 8'd1);
    chk("ack_y7_kept", {4'h0, y7}, 8'd8);
    frame_ack = 1'b0;
    tick();
    chk("post_ack_y0", {4'h0, y0}, 8'd9);
    d = 4'd10;
    tick();
    chk("post_ack_y1", {4'h0, y1}, 8'd10);

    // Reset mid-frame (4 writes so far: lanes 0..3); reset beats a transfer
    d = 4'd11; tick();
    d = 4'd12; tick();
    chk("pre_rst_y3", {4'h0, y3}, 8'd12);
    rst_n = 1'b0; d = 4'd13;
    tick();
    chk_all_y("midrst", 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    chk("midrst_fv", {7'd0, frame_valid}, 8'd0);
    chk("midrst_rdy", {7'd0, d_ready}, 8'd1);
    rst_n = 1'b1; d = 4'd5;
    tick();
    chk_all_y("after_rst", 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0);

    // Manual with overwrite: lanes 7,7,0..6
    rst_n = 1'b0; tick();
    rst_n = 1'b1; auto_mode = 1'b0;
    sel(7); d = 4'hA; tick();
    chk("man_y7a", {4'h0, y7}, 8'h0A);
    sel(7); d = 4'hB; tick();
    chk("man_y7b", {4'h0, y7}, 8'h0B);
    for (int i = 0; i < 7; i++) begin
      sel(i); d = 4'(i); tick();
      chk($sformatf("man_fv_%0d", i), {7'd0, frame_valid}, (i == 6) ? 8'd1 : 8'd0);
    end
    chk_all_y("man", 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'hB);

    // Ack, then keep ack high in FILL where it must be ignored
    d_valid = 1'b0; frame_ack = 1'b1;
    tick();
    chk("man_ack_fv", {7'd0, frame_valid}, 8'd0);

    // Mixed mode: auto lanes 0-2, manual lane 5, auto resumes at lane 3
    d_valid = 1'b1; auto_mode = 1'b1;
    d = 4'd1; tick();
    chk("mix_fill_ack_ign", {7'd0, d_ready}, 8'd1);
    frame_ack = 1'b0;
    d = 4'd2; tick();
    d = 4'd3; tick();
    auto_mode = 1'b0; sel(5); d = 4'd4; tick();
    chk("mix_y5_man", {4'h0, y5}, 8'd4);
    auto_mode = 1'b1;
    d = 4'd5; tick();
    chk("mix_y3", {4'h0, y3}, 8'd5);
    d = 4'd6; tick();
    d = 4'd7; tick();
    chk("mix_y5_over", {4'h0, y5}, 8'd7);
    d = 4'd8; tick();
    chk("mix_fv_early", {7'd0, frame_valid}, 8'd0);
    d = 4'd9; tick();
    chk("mix_fv", {7'd0, frame_valid}, 8'd1);
    chk_all_y("mix", 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9);
    d_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
